// File: rtl/fifo_pkg.sv
// Shared async-FIFO package: default geometry and Gray/binary helpers.
package fifo_pkg;

  localparam int unsigned ADDR_W = 9;
  localparam int unsigned PTR_W  = ADDR_W + 1;

  // Binary to reflected Gray code.
  function automatic logic [PTR_W-1:0] bin2gray(input logic [PTR_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Reflected Gray code back to binary (XOR prefix from the MSB down).
  function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] gray);
    logic [PTR_W-1:0] bin;
    bin = gray;
    for (int i = int'(PTR_W) - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_wptr_full_if.sv
// Producer-side bus of the FIFO write-pointer block.
interface fifo_wptr_full_if #(
  parameter int unsigned ADDR_W = fifo_pkg::ADDR_W
);
  localparam int unsigned PTR_W = ADDR_W + 1;

  logic              winc;
  logic [PTR_W-1:0]  rptr_sync;
  logic [ADDR_W-1:0] waddr;
  logic [PTR_W-1:0]  wptr;
  logic              wfull;
  logic              walmost_full;
  logic [PTR_W-1:0]  wlevel;
  logic              woverflow;
  logic              woverflow_sticky;

  // Producer / environment side.
  modport master (
    output winc, rptr_sync,
    input  waddr, wptr, wfull, walmost_full, wlevel, woverflow, woverflow_sticky
  );

  // Pointer block side.
  modport slave (
    input  winc, rptr_sync,
    output waddr, wptr, wfull, walmost_full, wlevel, woverflow, woverflow_sticky
  );
endinterface

// File: rtl/gray_to_bin.sv
// Parameterized combinational Gray-to-binary decoder (XOR prefix).
module gray_to_bin #(
  parameter int unsigned W = 10
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    bin = gray;
    for (int i = int'(W) - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
  end

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-domain pointer, full / almost-full / level and overflow generator.
module fifo_wptr_full #(
  parameter int unsigned ADDR_W    = fifo_pkg::ADDR_W,
  parameter int unsigned AF_MARGIN = 4
) (
  input  logic             clk,
  input  logic             rst,
  fifo_wptr_full_if.slave  bus
);

  localparam int unsigned PTR_W = ADDR_W + 1;
  localparam logic [PTR_W-1:0] DEPTH  = PTR_W'(2 ** ADDR_W);
  localparam logic [PTR_W-1:0] MARGIN = PTR_W'(AF_MARGIN);

  logic [PTR_W-1:0] wbin;
  logic [PTR_W-1:0] wgray;
  logic             wfull_q;
  logic             walmost_full_q;
  logic [PTR_W-1:0] wlevel_q;
  logic             woverflow_q;
  logic             woverflow_sticky_q;

  logic             accept;
  logic             reject;
  logic [PTR_W-1:0] wbin_next;
  logic [PTR_W-1:0] wgray_next;
  logic [PTR_W-1:0] rbin_sync;
  logic [PTR_W-1:0] level_next;
  logic [PTR_W-1:0] free_next;
  logic             full_next;
  logic             almost_full_next;

  gray_to_bin #(.W(PTR_W)) u_rptr_dec (
    .gray (bus.rptr_sync),
    .bin  (rbin_sync)
  );

  // Next pointer values and flag conditions from the current request.
  always_comb begin
    accept           = bus.winc && !wfull_q;
    reject           = bus.winc && wfull_q;
    wbin_next        = wbin + PTR_W'(accept);
    wgray_next       = wbin_next ^ (wbin_next >> 1);
    full_next        = (wgray_next == {~bus.rptr_sync[ADDR_W:ADDR_W-1],
                                       bus.rptr_sync[ADDR_W-2:0]});
    level_next       = wbin_next - rbin_sync;
    free_next        = DEPTH - level_next;
    almost_full_next = (free_next <= MARGIN);
  end

  // Pointer and status registers; the Gray pointer is registered so it
  // changes by exactly one bit per accepted write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbin               <= '0;
      wgray              <= '0;
      wfull_q            <= 1'b0;
      walmost_full_q     <= 1'b0;
      wlevel_q           <= '0;
      woverflow_q        <= 1'b0;
      woverflow_sticky_q <= 1'b0;
    end else begin
      wbin               <= wbin_next;
      wgray              <= wgray_next;
      wfull_q            <= full_next;
      walmost_full_q     <= almost_full_next;
      wlevel_q           <= level_next;
      woverflow_q        <= reject;
      woverflow_sticky_q <= woverflow_sticky_q | reject;
    end
  end

  assign bus.waddr            = wbin[ADDR_W-1:0];
  assign bus.wptr             = wgray;
  assign bus.wfull            = wfull_q;
  assign bus.walmost_full     = walmost_full_q;
  assign bus.wlevel           = wlevel_q;
  assign bus.woverflow        = woverflow_q;
  assign bus.woverflow_sticky = woverflow_sticky_q;

endmodule
